multicycle_control_unit: RTL

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RISC-V style control FSM: fetch/decode/exec/mem/writeback
// sequencing with memory wait timeout, sticky trap and retire counter.
module multicycle_control_unit #(
    parameter bit ENABLE_IMM_ALU = 1'b1,
    parameter int TIMEOUT        = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    input  logic             zero,
    output logic [1:0]       alu_op,
    output logic             alu_src,
    output logic             mem_reg,
    output logic             reg_write,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             retire,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    localparam logic [1:0] CAUSE_ILL = 2'b01;
    localparam logic [1:0] CAUSE_TMO = 2'b10;

    state_t           state_q;
    state_t           state_d;
    logic [6:0]       op_q;
    logic [31:0]      wait_q;
    logic             trap_q;
    logic [1:0]       cause_q;
    logic [1:0]       cause_d;
    logic [CNT_W-1:0] cnt_q;
    logic             waiting;
    logic             timeout_hit;
    logic             legal;

    assign legal = (opcode == OP_R) || (opcode == OP_LD) ||
                   (opcode == OP_ST) || (opcode == OP_BR) ||
                   (ENABLE_IMM_ALU && (opcode == OP_I));

    assign waiting = ((state_q == FETCH) || (state_q == MEM)) && !mem_ready;

    // This is the TIMEOUT-th consecutive stalled cycle; a ready beat wins.
    assign timeout_hit = (TIMEOUT > 0) && waiting &&
                         (wait_q == 32'(TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        alu_op    = 2'b00;
        alu_src   = 1'b0;
        mem_reg   = 1'b0;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        retire    = 1'b0;
        case (state_q)
            FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (timeout_hit) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TMO;
                end
            end
            DECODE: begin
                if (legal) begin
                    state_d = EXEC;
                end else begin
                    state_d = TRAP;
                    cause_d = CAUSE_ILL;
                end
            end
            EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_op  = 2'b10;
                        state_d = WB;
                    end
                    OP_I: begin
                        alu_op  = 2'b11;
                        alu_src = 1'b1;
                        state_d = WB;
                    end
                    OP_LD, OP_ST: begin
                        alu_src = 1'b1;
                        state_d = MEM;
                    end
                    OP_BR: begin
                        alu_op   = 2'b01;
                        pc_src   = 1'b1;
                        pc_write = zero;
                        retire   = 1'b1;
                        state_d  = FETCH;
                    end
                    default: begin
                        state_d = TRAP;
                        cause_d = CAUSE_ILL;
                    end
                endcase
            end
            MEM: begin
                mem_write = (op_q == OP_ST);
                mem_read  = (op_q != OP_ST);
                if (mem_ready) begin
                    if (op_q == OP_ST) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (timeout_hit) begin
                    state_d = TRAP;
                    cause_d = CAUSE_TMO;
                end
            end
            WB: begin
                reg_write = 1'b1;
                mem_reg   = (op_q == OP_LD);
                retire    = 1'b1;
                state_d   = FETCH;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = TRAP;
                cause_d = CAUSE_ILL;
            end
        endcase
        // Outputs go quiet the moment reset rises, not at the next edge.
        if (reset) begin
            alu_op    = 2'b00;
            alu_src   = 1'b0;
            mem_reg   = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            pc_write  = 1'b0;
            pc_src    = 1'b0;
            retire    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            op_q    <= 7'd0;
            wait_q  <= 32'd0;
            trap_q  <= 1'b0;
            cause_q <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            trap_q  <= (state_d == TRAP);
            if (state_q == DECODE) begin
                op_q <= opcode;
            end
            if (waiting && (state_d == state_q)) begin
                wait_q <= wait_q + 32'd1;
            end else begin
                wait_q <= 32'd0;
            end
            if (retire) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign retired_cnt = cnt_q;
    assign trap        = trap_q;
    assign trap_cause  = cause_q;
    assign state       = state_q;

endmodule
